alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Issue-side controller that drives the datapath ALU's 4-bit control code and 32-bit operands.
- Accepts one decoded MIPS instruction per transaction over a valid/ready handshake.
- Forms the operands, including the sign/zero extension that the ALU does not perform, and holds the code for a programmable number of cycles.
- Captures the ALU result or ZERO flag and presents a registered result with valid/ready back-pressure to writeback/branch logic.

Parameters:
ISSUE_CYCLES, 1, cycles alu_ctrl/operands held stable before sampling ALU outputs (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instruction fields valid
in_ready  out  1  controller can accept an instruction
in_opcode  in  6  instruction opcode
in_funct  in  6  R-type funct field
in_shamt  in  5  shift amount
in_imm  in  16  immediate field
in_rs_data  in  32  rs register value
in_rt_data  in  32  rt register value
alu_in1  out  32  ALU operand 1
alu_in2  out  32  ALU operand 2
alu_ctrl  out  4  ALU control code
alu_out  in  32  ALU result
alu_zero  in  1  ALU ZERO flag
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  32  captured result
res_branch_taken  out  1  beq outcome
res_no_alu  out  1  instruction needed no ALU op (jal, jr)
res_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; in_ready=1; res_valid=0; res_data=0; res_branch_taken=0; res_no_alu=0; res_illegal=0; alu_in1=0; alu_in2=0; alu_ctrl=4'b1111 (NOP: no ALU operation selected, ALU outputs hold). Reset overrides any state, including mid-ISSUE and DONE; an in-flight instruction is dropped and no result is produced.
- Decode, registered at accept:
  - R-type (opcode 000000):
    - funct 100000 add: code 0000, in1=rs, in2=rt.
    - funct 100100 and: code 0101, in1=rs, in2=rt.
    - funct 100111 nor: code 0111, in1=rs, in2=rt.
    - funct 101010 slt: code 1011, in1=rs, in2=rt.
    - funct 000000 sll: code 0100, in1=rt, in2={27'b0,shamt}.
    - funct 001000 jr: no_alu.
    - Any other funct: illegal.
  - addi 001000: code 0000, in2=sign-extended imm.
  - andi 001100: code 0101, in2=zero-extended imm.
  - lw 100011 / sw 101011: code 0010, in2=sign-extended imm.
  - beq 000100: code 1000, in1=rs, in2=rt.
  - jal 000011: no_alu.
  - Any other opcode: illegal.
  - I-type in1=rs.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE:
    - in_ready=1, alu_ctrl=1111.
    - On in_valid=1: latch the decode. If ALU-op, go to ISSUE with counter=ISSUE_CYCLES-1. If no_alu or illegal, go directly to DONE with res_data=0.
  - ISSUE:
    - in_ready=0; alu_ctrl and operands driven from the latched values and held stable.
    - Counter decrements each cycle. At the edge where counter==0, capture and go to DONE.
    - beq: res_branch_taken<=alu_zero, res_data<=0.
    - All other ALU ops: res_data<=alu_out, res_branch_taken<=0.
    - alu_ctrl returns to 1111 on leaving ISSUE.
  - DONE:
    - res_valid=1; all res_* outputs held stable until res_valid&res_ready.
    - On that handshake, go to IDLE and clear res_valid.
    - in_ready=0 throughout DONE; there is no overlap of transactions.
- Latency, accept edge to res_valid high:
  - ALU ops: ISSUE_CYCLES+1 edges, i.e. res_valid is visible in the (ISSUE_CYCLES+1)th cycle after accept.
  - no_alu and illegal: 1 edge.
- Throughput: one instruction per ISSUE_CYCLES+2 cycles with res_ready tied high.
- Flag exclusivity: res_no_alu and res_illegal are mutually exclusive; both are 0 for ALU ops.
- Width rules: the controller does not truncate or alter alu_out.

Test Plan:
- add: rs=5, rt=7 -> alu_ctrl=0000 with in1=5, in2=7 during ISSUE; res_data=12, res_valid after 2 edges (ISSUE_CYCLES=1).
- addi and andi, in_imm=16'hFFFE, rs=10:
  - addi -> in2=32'hFFFFFFFE, res_data=8.
  - andi -> in2=32'h0000FFFE.
- beq: rs=rt=32'h1234 -> res_branch_taken=1, res_data=0; rs=3, rt=4 -> res_branch_taken=0.
- slt, rs=2, rt=9 -> res_data=1; opcode 111111 -> res_illegal=1 after 1 edge, alu_ctrl never leaves 1111; jal -> res_no_alu=1.
- Back-pressure: hold res_ready=0 for 5 cycles -> res_* stable, in_ready=0, and a new in_valid is ignored; then res_ready=1 -> IDLE on the next edge.
- ISSUE_CYCLES=3: operands/alu_ctrl stable for exactly 3 cycles, res_valid at edge 4. reset_n=0 during ISSUE -> next cycle IDLE, alu_ctrl=1111, res_valid=0, no result.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue-side controller for the datapath ALU. It accepts one decoded MIPS
//   instruction over a valid/ready handshake and builds the two operands,
//   including the sign/zero extension that the ALU does not perform. It holds
//   the ALU control code and operands stable for ISSUE_CYCLES cycles, then
//   captures the ALU result or ZERO flag. The result is presented as a
//   registered transaction with valid/ready back-pressure.
//
// Ports
//   clk, reset_n              rising-edge clock, synchronous active-low reset
//   in_valid / in_ready       instruction handshake
//   in_opcode, in_funct,
//   in_shamt, in_imm          decoded instruction fields
//   in_rs_data, in_rt_data    register operands
//   alu_in1, alu_in2,
//   alu_ctrl                  registered ALU drive (4'b1111 = no operation)
//   alu_out, alu_zero         ALU result and ZERO flag
//   res_valid / res_ready     result handshake
//   res_data                  captured ALU result (0 for beq/no-ALU/illegal)
//   res_branch_taken          beq outcome
//   res_no_alu, res_illegal   jal/jr marker, unsupported opcode/funct marker

module alu_issue_ctrl #(
   parameter int unsigned ISSUE_CYCLES = 1   // legal 1..15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_opcode,
   input  logic [5:0]  in_funct,
   input  logic [4:0]  in_shamt,
   input  logic [15:0] in_imm,
   input  logic [31:0] in_rs_data,
   input  logic [31:0] in_rt_data,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_branch_taken,
   output logic        res_no_alu,
   output logic        res_illegal
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] CTRL_NOP = 4'b1111;
   localparam logic [3:0] CNT_INIT = 4'(ISSUE_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_is_beq;

   logic [3:0]  w_code;
   logic [31:0] w_in1;
   logic [31:0] w_in2;
   logic        w_no_alu;
   logic        w_illegal;
   logic        w_is_beq;
   logic [31:0] w_imm_sext;
   logic [31:0] w_imm_zext;

   assign w_imm_sext = {{16{in_imm[15]}}, in_imm};
   assign w_imm_zext = {16'h0000, in_imm};

   // Instruction decode; only latched when the instruction is accepted.
   always_comb begin
      w_code    = CTRL_NOP;
      w_in1     = in_rs_data;
      w_in2     = '0;
      w_no_alu  = 1'b0;
      w_illegal = 1'b0;
      w_is_beq  = 1'b0;
      case (in_opcode)
         6'b000000: begin
            case (in_funct)
               6'b100000: begin w_code = 4'b0000; w_in2 = in_rt_data; end
               6'b100100: begin w_code = 4'b0101; w_in2 = in_rt_data; end
               6'b100111: begin w_code = 4'b0111; w_in2 = in_rt_data; end
               6'b101010: begin w_code = 4'b1011; w_in2 = in_rt_data; end
               6'b000000: begin
                  // sll shifts rt, not rs, by the shamt field
                  w_code = 4'b0100;
                  w_in1  = in_rt_data;
                  w_in2  = {27'b0, in_shamt};
               end
               6'b001000: w_no_alu  = 1'b1;
               default:   w_illegal = 1'b1;
            endcase
         end
         6'b001000: begin w_code = 4'b0000; w_in2 = w_imm_sext; end
         6'b001100: begin w_code = 4'b0101; w_in2 = w_imm_zext; end
         6'b100011,
         6'b101011: begin w_code = 4'b0010; w_in2 = w_imm_sext; end
         6'b000100: begin
            w_code   = 4'b1000;
            w_in2    = in_rt_data;
            w_is_beq = 1'b1;
         end
         6'b000011: w_no_alu  = 1'b1;
         default:   w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_is_beq         <= 1'b0;
         in_ready         <= 1'b1;
         alu_in1          <= '0;
         alu_in2          <= '0;
         alu_ctrl         <= CTRL_NOP;
         res_valid        <= 1'b0;
         res_data         <= '0;
         res_branch_taken <= 1'b0;
         res_no_alu       <= 1'b0;
         res_illegal      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  in_ready         <= 1'b0;
                  res_data         <= '0;
                  res_branch_taken <= 1'b0;
                  res_no_alu       <= w_no_alu;
                  res_illegal      <= w_illegal;
                  if (w_no_alu || w_illegal) begin
                     // Nothing to execute: the result is ready immediately
                     // and the ALU drive is left untouched at NOP.
                     r_state   <= DONE;
                     res_valid <= 1'b1;
                  end else begin
                     r_state  <= ISSUE;
                     r_cnt    <= CNT_INIT;
                     r_is_beq <= w_is_beq;
                     alu_ctrl <= w_code;
                     alu_in1  <= w_in1;
                     alu_in2  <= w_in2;
                  end
               end
            end
            ISSUE: begin
               if (r_cnt == '0) begin
                  if (r_is_beq) begin
                     res_branch_taken <= alu_zero;
                     res_data         <= '0;
                  end else begin
                     res_branch_taken <= 1'b0;
                     res_data         <= alu_out;
                  end
                  alu_ctrl  <= CTRL_NOP;
                  res_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
